// File: rtl/tile_pkg.sv
// Shared constants, transfer-operation encoding and the planar pixel extraction
// helper for the tile pixel serializer.
package tile_pkg;

  localparam int TILE_PLANES = 4;
  localparam int TILE_PIXELS = 8;
  localparam int TILE_ATTRW  = 8;
  localparam int TILE_WORDW  = TILE_PLANES * TILE_PIXELS;
  localparam int TILE_POSW   = $clog2(TILE_WORDW);

  typedef enum logic [1:0] {
    SH_HOLD  = 2'd0,
    SH_XFER  = 2'd1,
    SH_SHIFT = 2'd2,
    SH_UNDER = 2'd3
  } shift_op_e;

  // Pixel idx of a planar word: unflipped words read each plane MSB first.
  function automatic logic [TILE_PLANES-1:0] tile_pixel(
    input logic [TILE_WORDW-1:0] word,
    input int unsigned           idx,
    input logic                  flip
  );
    logic [TILE_PLANES-1:0] px;
    logic [TILE_POSW-1:0]   pos;
    int unsigned            bitSel;
    px     = '0;
    bitSel = flip ? idx : (TILE_PIXELS - 1 - idx);
    for (int p = 0; p < TILE_PLANES; p++) begin
      pos = TILE_POSW'(p * TILE_PIXELS + bitSel);
      px  = {word[pos], px[TILE_PLANES-1:1]};
    end
    return px;
  endfunction

endpackage

// File: rtl/tile_pixel_shifter_plane_shift.sv
// One bitplane of the serializer: parallel-loaded shift register whose head bit
// is the next pixel's contribution from this plane.
module plane_shift
  import tile_pkg::*;
#(
  parameter int PIXELS = TILE_PIXELS
) (
  input  logic              clk,
  input  logic              nRES,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic              flip_i,
  input  logic [PIXELS-1:0] data_i,
  output logic              head_o
);

  logic [PIXELS-1:0] data_q, data_d;
  logic              flip_q, flip_d;

  // Pixel 0 leaves through the top module directly, so the load pre-shifts by one.
  always_comb begin
    data_d = data_q;
    flip_d = flip_q;
    if (load_i) begin
      flip_d = flip_i;
      data_d = flip_i ? (data_i >> 1) : (data_i << 1);
    end else if (shift_i) begin
      data_d = flip_q ? (data_q >> 1) : (data_q << 1);
    end
  end

  always_ff @(posedge clk or negedge nRES) begin
    if (!nRES) begin
      data_q <= '0;
      flip_q <= 1'b0;
    end else begin
      data_q <= data_d;
      flip_q <= flip_d;
    end
  end

  assign head_o = flip_q ? data_q[0] : data_q[PIXELS-1];

endmodule

// File: rtl/tile_pixel_shifter.sv
// Double-buffered planar tile serializer: a hold register takes one ROM word per
// row and feeds a per-plane shifter that emits one pixel index per cen.
module tile_pixel_shifter
  import tile_pkg::*;
#(
  parameter int PLANES = TILE_PLANES,
  parameter int PIXELS = TILE_PIXELS,
  parameter int ATTRW  = TILE_ATTRW
) (
  input  logic                     clk,
  input  logic                     nRES,
  input  logic                     cen,
  input  logic                     load,
  input  logic [PLANES*PIXELS-1:0] rom_data,
  input  logic [ATTRW-1:0]         attr_in,
  input  logic                     flip_in,
  output logic [PLANES-1:0]        pix_out,
  output logic [ATTRW-1:0]         attr_out,
  output logic                     pix_valid,
  output logic                     last_pix,
  output logic                     overrun
);

  localparam int              CNTW     = $clog2(PIXELS + 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(PIXELS - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  logic [PLANES*PIXELS-1:0] holdData_q, holdData_d;
  logic [ATTRW-1:0]         holdAttr_q, holdAttr_d;
  logic                     holdFlip_q, holdFlip_d;
  logic                     holdFull_q, holdFull_d;
  logic [CNTW-1:0]          cnt_q, cnt_d;
  logic [PLANES-1:0]        pix_q, pix_d;
  logic [ATTRW-1:0]         attr_q, attr_d;
  logic                     valid_q, valid_d;
  logic                     last_q, last_d;
  logic                     overrun_q, overrun_d;

  shift_op_e         op;
  logic [PLANES-1:0] pixZero;
  logic [PLANES-1:0] shiftHead;

  assign pixZero = tile_pixel(holdData_q, 0, holdFlip_q);

  for (genvar p = 0; p < PLANES; p++) begin : g_plane
    plane_shift #(
      .PIXELS(PIXELS)
    ) u_plane (
      .clk    (clk),
      .nRES   (nRES),
      .load_i (op == SH_XFER),
      .shift_i(op == SH_SHIFT),
      .flip_i (holdFlip_q),
      .data_i (holdData_q[p*PIXELS +: PIXELS]),
      .head_o (shiftHead[p])
    );
  end

  always_comb begin
    op = SH_HOLD;
    if (cen) begin
      if (holdFull_q && (cnt_q == '0)) begin
        op = SH_XFER;
      end else if (cnt_q != '0) begin
        op = SH_SHIFT;
      end else begin
        op = SH_UNDER;
      end
    end
  end

  // A load while the hold word is still waiting for the shifter replaces it.
  always_comb begin
    holdData_d = holdData_q;
    holdAttr_d = holdAttr_q;
    holdFlip_d = holdFlip_q;
    holdFull_d = holdFull_q;
    cnt_d      = cnt_q;
    pix_d      = pix_q;
    attr_d     = attr_q;
    valid_d    = valid_q;
    last_d     = last_q;
    overrun_d  = overrun_q;

    unique case (op)
      SH_XFER: begin
        pix_d      = pixZero;
        attr_d     = holdAttr_q;
        valid_d    = 1'b1;
        last_d     = (PIXELS == 1);
        cnt_d      = CNT_FULL;
        holdFull_d = 1'b0;
      end
      SH_SHIFT: begin
        pix_d  = shiftHead;
        cnt_d  = cnt_q - CNT_ONE;
        last_d = (cnt_q == CNT_ONE);
      end
      SH_UNDER: begin
        pix_d   = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
      default: ;
    endcase

    if (cen && load) begin
      holdData_d = rom_data;
      holdAttr_d = attr_in;
      holdFlip_d = flip_in;
      holdFull_d = 1'b1;
      if (holdFull_q && (op != SH_XFER)) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nRES) begin
    if (!nRES) begin
      holdData_q <= '0;
      holdAttr_q <= '0;
      holdFlip_q <= 1'b0;
      holdFull_q <= 1'b0;
      cnt_q      <= '0;
      pix_q      <= '0;
      attr_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      holdData_q <= holdData_d;
      holdAttr_q <= holdAttr_d;
      holdFlip_q <= holdFlip_d;
      holdFull_q <= holdFull_d;
      cnt_q      <= cnt_d;
      pix_q      <= pix_d;
      attr_q     <= attr_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      overrun_q  <= overrun_d;
    end
  end

  assign pix_out   = pix_q;
  assign attr_out  = attr_q;
  assign pix_valid = valid_q;
  assign last_pix  = last_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_tile_pixel_shifter.sv
// Scoreboard bench for tile_pixel_shifter: each loaded word queues its eight
// expected pixels, which are popped whenever the serializer shows a valid pixel.
module tb_tile_pixel_shifter;
  import tile_pkg::*;

  typedef struct packed {
    logic [3:0] pix;
    logic [7:0] attr;
    logic       last;
  } expItem_t;

  logic        clk = 1'b0;
  logic        nRES;
  logic        cen;
  logic        load;
  logic [31:0] rom_data;
  logic [7:0]  attr_in;
  logic        flip_in;
  logic [3:0]  pix_out;
  logic [7:0]  attr_out;
  logic        pix_valid;
  logic        last_pix;
  logic        overrun;

  expItem_t expQ[$];
  int       checkCount = 0;
  int       passCount  = 0;

  // Word with plane0=F0, plane1=CC, plane2=AA, plane3=00.
  localparam logic [31:0] WORD_A = 32'h00AA_CCF0;
  logic [3:0] seqNoFlip[8] = '{4'd7, 4'd3, 4'd5, 4'd1, 4'd6, 4'd2, 4'd4, 4'd0};
  logic [3:0] seqFlip[8]   = '{4'd0, 4'd4, 4'd2, 4'd6, 4'd1, 4'd5, 4'd3, 4'd7};

  always #5 clk = ~clk;

  tile_pixel_shifter dut (
    .clk      (clk),
    .nRES     (nRES),
    .cen      (cen),
    .load     (load),
    .rom_data (rom_data),
    .attr_in  (attr_in),
    .flip_in  (flip_in),
    .pix_out  (pix_out),
    .attr_out (attr_out),
    .pix_valid(pix_valid),
    .last_pix (last_pix),
    .overrun  (overrun)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic pushWord(input logic [31:0] word, input logic [7:0] at, input logic fl);
    expItem_t e;
    for (int i = 0; i < 8; i++) begin
      e.pix  = tile_pixel(word, i, fl);
      e.attr = at;
      e.last = (i == 7);
      expQ.push_back(e);
    end
  endtask

  task automatic scoreboardStep();
    expItem_t e;
    if (pix_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_valid", pix_valid, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("sb_pix", pix_out, e.pix);
        checkOutput("sb_attr", attr_out, e.attr);
        checkOutput("sb_last", last_pix, e.last);
      end
    end else begin
      checkOutput("idle_pix", pix_out, 0);
      checkOutput("idle_last", last_pix, 0);
    end
  endtask

  // One cen edge with the given inputs, then scoreboard the new outputs.
  task automatic applyStimulus(input logic ld, input logic [31:0] data, input logic [7:0] at,
                               input logic fl, input bit pushIt);
    load     = ld;
    rom_data = data;
    attr_in  = at;
    flip_in  = fl;
    cen      = 1'b1;
    @(posedge clk);
    #1;
    cen  = 1'b0;
    load = 1'b0;
    if (ld && pushIt) pushWord(data, at, fl);
    scoreboardStep();
  endtask

  // A clock edge with cen low and a junk load that must be ignored.
  task automatic idleCycle(input logic [3:0] expPix, input logic expValid);
    load     = 1'b1;
    rom_data = 32'hFFFF_FFFF;
    attr_in  = 8'hEE;
    flip_in  = 1'b1;
    cen      = 1'b0;
    @(posedge clk);
    #1;
    load = 1'b0;
    checkOutput("cen_off_pix", pix_out, expPix);
    checkOutput("cen_off_valid", pix_valid, expValid);
  endtask

  task automatic doReset();
    nRES = 1'b0;
    cen  = 1'b0;
    load = 1'b0;
    #3;
    checkOutput("rst_pix", pix_out, 0);
    checkOutput("rst_attr", attr_out, 0);
    checkOutput("rst_valid", pix_valid, 0);
    checkOutput("rst_last", last_pix, 0);
    checkOutput("rst_overrun", overrun, 0);
    expQ.delete();
    @(negedge clk);
    nRES = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    nRES     = 1'b0;
    cen      = 1'b0;
    load     = 1'b0;
    rom_data = '0;
    attr_in  = '0;
    flip_in  = 1'b0;
    #12;
    doReset();

    // Single unflipped word, then underrun.
    applyStimulus(1'b1, WORD_A, 8'h5A, 1'b0, 1'b1);
    checkOutput("s1_latency", pix_valid, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput("s1_pix", pix_out, seqNoFlip[i]);
      checkOutput("s1_valid", pix_valid, 1);
      checkOutput("s1_attr", attr_out, 8'h5A);
      checkOutput("s1_last", last_pix, (i == 7));
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("s1_drop_valid", pix_valid, 0);
    checkOutput("s1_drop_pix", pix_out, 0);
    checkOutput("s1_attr_held", attr_out, 8'h5A);

    // Same word flipped.
    applyStimulus(1'b1, WORD_A, 8'h5A, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput("s2_pix", pix_out, seqFlip[i]);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("s2_drained", expQ.size(), 0);

    // Seamless stream of four words.
    for (int t = 0; t < 34; t++) begin
      if ((t % 8) == 0 && t < 32)
        applyStimulus(1'b1, $urandom(), 8'(t / 8 + 1), 1'((t / 8) % 2), 1'b1);
      else
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      if (t >= 1 && t <= 32) begin
        checkOutput("s3_gapless", pix_valid, 1);
        checkOutput("s3_attr", attr_out, (t - 1) / 8 + 1);
      end
    end
    checkOutput("s3_overrun", overrun, 0);
    checkOutput("s3_drained", expQ.size(), 0);

    // Overrun: the second word is overwritten by the third.
    for (int t = 0; t < 26; t++) begin
      if (t == 0 || t == 2 || t == 3 || t == 12)
        applyStimulus(1'b1, $urandom(), 8'(8'h10 + t), 1'b0, (t != 2));
      else
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      if (t >= 1 && t <= 24) checkOutput("s4_gapless", pix_valid, 1);
      if (t == 2) checkOutput("s4_no_overrun_yet", overrun, 0);
      if (t >= 3) checkOutput("s4_overrun_sticky", overrun, 1);
    end
    checkOutput("s4_drained", expQ.size(), 0);

    // cen one-on, two-off; ignored loads while cen is low.
    doReset();
    applyStimulus(1'b1, WORD_A, 8'h5A, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      idleCycle((i == 0) ? 4'd0 : seqNoFlip[(i == 0) ? 0 : i - 1], (i != 0));
      idleCycle((i == 0) ? 4'd0 : seqNoFlip[(i == 0) ? 0 : i - 1], (i != 0));
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput("s5_pix", pix_out, seqNoFlip[i]);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("s5_no_ghost_word", pix_valid, 0);

    // Asynchronous reset mid-word with a second word buffered.
    applyStimulus(1'b1, WORD_A, 8'h66, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h1234_5678, 8'h67, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    nRES = 1'b0;
    #1;
    checkOutput("s6_async_pix", pix_out, 0);
    checkOutput("s6_async_attr", attr_out, 0);
    checkOutput("s6_async_valid", pix_valid, 0);
    checkOutput("s6_async_last", last_pix, 0);
    expQ.delete();
    #7;
    nRES = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("s6_hold_discarded", pix_valid, 0);
    applyStimulus(1'b1, WORD_A, 8'h77, 1'b0, 1'b1);
    checkOutput("s6_capture_edge", pix_valid, 0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("s6_first_valid", pix_valid, 1);
    checkOutput("s6_first_pix", pix_out, 4'd7);
    checkOutput("s6_first_attr", attr_out, 8'h77);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("s6_drained", expQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
